// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Forwarding and hazard control for the EX-stage operand muxes.
// Tracks the destinations of instructions in EX, MEM and WB and compares
// them against the ID-stage sources. Produces:
//   - registered operand-A/B select codes for EX,
//   - a combinational load-use stall,
//   - a registered bubble flag.
// Select codes: 00 = register file, 01 = EX/MEM, 10 = MEM/WB, 11 = late WB.
// Optional build macro FWD_WB_BYPASS_EN: the WB slot takes part in
// matching and code 11 is produced. When the macro is undefined, the WB
// slot is not stored at all.
module fwd_hazard_ctrl #(
    parameter int RB           = 5,
    parameter int R0_HARDWIRED = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RB-1:0] id_rs1,
    input  logic [RB-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [RB-1:0] id_rd,
    input  logic          id_wr,
    input  logic          id_load,
    input  logic          flush,
    output logic          stall,
    output logic          bubble,
    output logic [0:1]    sel_a,
    output logic [0:1]    sel_b
);

    // Operand mux select codes. The first (left) bit is the mux MSB, which
    // lands in bit 0 of the [0:1] select ports.
    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_EX  = 2'b01,
        SEL_MEM = 2'b10,
        SEL_WB  = 2'b11
    } sel_t;

    // Slot contents used for matching. The load flag only matters while
    // the producer sits in EX, so it is kept beside the EX slot rather
    // than being carried down the pipe.
    typedef struct packed {
        logic          v;
        logic [RB-1:0] rd;
        logic          wr;
    } slot_t;

    slot_t ex_q;
    logic  ex_ld_q;
    slot_t mem_q;
`ifdef FWD_WB_BYPASS_EN
    slot_t wb_q;
`endif

    sel_t code_a;
    sel_t code_b;
    logic ex_hit_rs1;
    logic ex_hit_rs2;
    logic issue;

    // True when slot s produces register r and r is a forwardable register.
    function automatic logic slot_match(input slot_t s, input logic [RB-1:0] r);
        logic r0_blocked;
        r0_blocked = (R0_HARDWIRED != 0) && (r == '0);
        return s.v && s.wr && (s.rd == r) && !r0_blocked;
    endfunction

    // EX-slot compares feed both the stall and the select logic. The
    // stall path deliberately touches only ID inputs and the EX slot.
    always_comb begin
        ex_hit_rs1 = id_use_rs1 && slot_match(ex_q, id_rs1);
        ex_hit_rs2 = id_use_rs2 && slot_match(ex_q, id_rs2);
    end

    // Load-use hazard: the load's data is not ready for the next EX
    // cycle. A flush kills the ID instruction, so it never stalls.
    always_comb begin
        stall = id_valid && !flush && ex_ld_q && (ex_hit_rs1 || ex_hit_rs2);
        issue = id_valid && !flush && !stall;
    end

    // Operand-A select, nearest producer first.
    always_comb begin
        // NOTE: default assignment first so every path drives code_a and
        // no latch is inferred.
        code_a = SEL_RF;
        if (ex_hit_rs1) begin
            code_a = SEL_EX;
        end else if (id_use_rs1 && slot_match(mem_q, id_rs1)) begin
            code_a = SEL_MEM;
        end
`ifdef FWD_WB_BYPASS_EN
        else if (id_use_rs1 && slot_match(wb_q, id_rs1)) begin
            code_a = SEL_WB;
        end
`endif
    end

    // Operand-B select, nearest producer first.
    always_comb begin
        code_b = SEL_RF;
        if (ex_hit_rs2) begin
            code_b = SEL_EX;
        end else if (id_use_rs2 && slot_match(mem_q, id_rs2)) begin
            code_b = SEL_MEM;
        end
`ifdef FWD_WB_BYPASS_EN
        else if (id_use_rs2 && slot_match(wb_q, id_rs2)) begin
            code_b = SEL_WB;
        end
`endif
    end

    // Slot tracking: advance the pipe every cycle; EX takes the ID
    // instruction when it issues, otherwise a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments throughout sequential logic so
            // every slot samples its upstream value from before the edge.
            ex_q    <= '0;
            ex_ld_q <= 1'b0;
            mem_q   <= '0;
`ifdef FWD_WB_BYPASS_EN
            wb_q    <= '0;
`endif
        end else begin
            mem_q <= ex_q;
`ifdef FWD_WB_BYPASS_EN
            wb_q  <= mem_q;
`endif
            if (issue) begin
                ex_q    <= '{v: 1'b1, rd: id_rd, wr: id_wr};
                ex_ld_q <= id_load;
            end else begin
                ex_q    <= '0;
                ex_ld_q <= 1'b0;
            end
        end
    end

    // Registered select codes and bubble flag for the EX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a  <= SEL_RF;
            sel_b  <= SEL_RF;
            bubble <= 1'b1;
        end else if (issue) begin
            sel_a  <= code_a;
            sel_b  <= code_b;
            bubble <= 1'b0;
        end else begin
            sel_a  <= SEL_RF;
            sel_b  <= SEL_RF;
            bubble <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl
// Self-checking bench for fwd_hazard_ctrl: directed scenarios with fixed
// expected codes, then randomized traffic against a history-based model.
// Honours FWD_WB_BYPASS_EN the same way as the design.
module tb_fwd_hazard_ctrl;

    localparam int RB = 5;
    localparam int R0_HARDWIRED = 1;
`ifdef FWD_WB_BYPASS_EN
    localparam int DEPTH = 3;
    localparam logic [1:0] DIST3_CODE = 2'b11;
`else
    localparam int DEPTH = 2;
    localparam logic [1:0] DIST3_CODE = 2'b00;
`endif

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [RB-1:0] id_rs1;
    logic [RB-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [RB-1:0] id_rd;
    logic          id_wr;
    logic          id_load;
    logic          flush;
    logic          stall;
    logic          bubble;
    logic [0:1]    sel_a;
    logic [0:1]    sel_b;

    int n_cmp = 0;
    int n_err = 0;

    fwd_hazard_ctrl #(.RB(RB), .R0_HARDWIRED(R0_HARDWIRED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_wr      (id_wr),
        .id_load    (id_load),
        .flush      (flush),
        .stall      (stall),
        .bubble     (bubble),
        .sel_a      (sel_a),
        .sel_b      (sel_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a history of what entered EX, most recent first.
    // hist[0] is the instruction in EX now, hist[1] one cycle older, etc.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } inst_t;

    inst_t      hist[$];
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic       exp_bubble;

    function automatic bit m_writes(int d, int r);
        if (hist.size() <= d) return 1'b0;
        if (R0_HARDWIRED != 0 && r == 0) return 1'b0;
        return hist[d].v && hist[d].wr && hist[d].rd == r;
    endfunction

    // Code = distance to nearest older producer (1..DEPTH), 0 if none.
    function automatic logic [1:0] m_code(bit used, int r);
        if (!used) return 2'd0;
        for (int d = 0; d < DEPTH; d++)
            if (m_writes(d, r)) return 2'(d + 1);
        return 2'd0;
    endfunction

    function automatic bit m_stall();
        if (!id_valid || flush || hist.size() == 0) return 1'b0;
        if (!hist[0].ld) return 1'b0;
        return (id_use_rs1 && m_writes(0, int'(id_rs1))) ||
               (id_use_rs2 && m_writes(0, int'(id_rs2)));
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_a = 2'd0;
        exp_b = 2'd0;
        exp_bubble = 1'b1;
    endtask

    task automatic drive(bit v, int rs1, int rs2, bit u1, bit u2,
                         int rd, bit wr, bit ld, bit fl);
        id_valid   = v;
        id_rs1     = RB'(rs1);
        id_rs2     = RB'(rs2);
        id_use_rs1 = u1;
        id_use_rs2 = u2;
        id_rd      = RB'(rd);
        id_wr      = wr;
        id_load    = ld;
        flush      = fl;
        #1;
    endtask

    // One clock: model decides issue from pre-edge inputs, DUT clocks,
    // then we land 1 time unit after the edge.
    task automatic tick();
        bit         issue;
        logic [1:0] ca;
        logic [1:0] cb;
        inst_t      e;
        issue = id_valid && !flush && !m_stall();
        ca = m_code(id_use_rs1, int'(id_rs1));
        cb = m_code(id_use_rs2, int'(id_rs2));
        e.v  = issue;
        e.rd = int'(id_rd);
        e.wr = id_wr;
        e.ld = id_load;
        @(posedge clk);
        hist.push_front(e);
        if (hist.size() > 3) void'(hist.pop_back());
        exp_a = issue ? ca : 2'd0;
        exp_b = issue ? cb : 2'd0;
        exp_bubble = !issue;
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        // Hazard-looking ID inputs while in reset: EX is empty, so no stall.
        drive(1, 4, 4, 1, 1, 4, 1, 1, 0);
        model_reset();
        #8;
        n_cmp++; if (sel_a !== 2'b00) begin n_err++; $display("FAIL reset_sel_a: got %b want 00", sel_a); end
        n_cmp++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL reset_sel_b: got %b want 00", sel_b); end
        n_cmp++; if (bubble !== 1'b1) begin n_err++; $display("FAIL reset_bubble: got %b want 1", bubble); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_ex_forward();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);              // add r3,r1,r2
        tick();
        drive(1, 3, 3, 1, 1, 5, 1, 0, 0);              // sub r5,r3,r3
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL exfwd_stall: got %b want 0", stall); end
        tick();
        n_cmp++; if (sel_a !== 2'b01) begin n_err++; $display("FAIL exfwd_sel_a: got %b want 01", sel_a); end
        n_cmp++; if (sel_b !== 2'b01) begin n_err++; $display("FAIL exfwd_sel_b: got %b want 01", sel_b); end
        n_cmp++; if (bubble !== 1'b0) begin n_err++; $display("FAIL exfwd_bubble: got %b want 0", bubble); end
        drain();
    endtask

    task automatic test_load_use();
        drive(1, 10, 0, 1, 0, 4, 1, 1, 0);             // lw r4,0(r10)
        tick();
        drive(1, 4, 1, 1, 1, 6, 1, 0, 0);              // add r6,r4,r1
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL ldu_stall1: got %b want 1", stall); end
        tick();
        n_cmp++; if (bubble !== 1'b1) begin n_err++; $display("FAIL ldu_bubble1: got %b want 1", bubble); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL ldu_stall2: got %b want 0", stall); end
        tick();
        n_cmp++; if (bubble !== 1'b0) begin n_err++; $display("FAIL ldu_bubble2: got %b want 0", bubble); end
        n_cmp++; if (sel_a !== 2'b10) begin n_err++; $display("FAIL ldu_sel_a: got %b want 10", sel_a); end
        n_cmp++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL ldu_sel_b: got %b want 00", sel_b); end
        drain();
    endtask

    task automatic test_wb_distance();
        drive(1, 1, 2, 1, 1, 7, 1, 0, 0);   tick();    // writer r7
        drive(1, 11, 12, 1, 1, 20, 1, 0, 0); tick();   // independent
        drive(1, 13, 14, 1, 1, 21, 1, 0, 0); tick();   // independent
        drive(1, 7, 7, 1, 1, 22, 1, 0, 0);  tick();    // reader r7
        n_cmp++; if (sel_a !== DIST3_CODE) begin n_err++; $display("FAIL wb_sel_a: got %b want %b", sel_a, DIST3_CODE); end
        n_cmp++; if (sel_b !== DIST3_CODE) begin n_err++; $display("FAIL wb_sel_b: got %b want %b", sel_b, DIST3_CODE); end
        drain();
    endtask

    task automatic test_r0();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0);   tick();    // writer r0
        drive(1, 0, 0, 1, 1, 8, 1, 0, 0);   tick();    // reader r0
        n_cmp++; if (sel_a !== 2'b00) begin n_err++; $display("FAIL r0_sel_a: got %b want 00", sel_a); end
        n_cmp++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL r0_sel_b: got %b want 00", sel_b); end
        drain();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 0);   tick();    // lw r0
        drive(1, 0, 0, 1, 1, 8, 1, 0, 0);              // use r0
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_ld_stall: got %b want 0", stall); end
        tick();
        n_cmp++; if (bubble !== 1'b0) begin n_err++; $display("FAIL r0_ld_bubble: got %b want 0", bubble); end
        drain();
    endtask

    task automatic test_flush();
        drive(1, 1, 0, 1, 0, 2, 1, 1, 0);   tick();    // lw r2
        drive(1, 2, 2, 1, 1, 9, 1, 0, 1);              // dependent + flush
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        n_cmp++; if (bubble !== 1'b1) begin n_err++; $display("FAIL flush_bubble: got %b want 1", bubble); end
        n_cmp++; if (sel_a !== 2'b00) begin n_err++; $display("FAIL flush_sel_a: got %b want 00", sel_a); end
        n_cmp++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL flush_sel_b: got %b want 00", sel_b); end
        drain();
    endtask

    task automatic test_nearest_and_reset();
        drive(1, 1, 2, 1, 1, 9, 1, 0, 0);   tick();    // writer r9
        drive(1, 3, 4, 1, 1, 9, 1, 0, 0);   tick();    // writer r9 again
        drive(1, 9, 9, 1, 1, 10, 1, 0, 0);  tick();    // reader r9
        n_cmp++; if (sel_a !== 2'b01) begin n_err++; $display("FAIL near_sel_a: got %b want 01", sel_a); end
        n_cmp++; if (sel_b !== 2'b01) begin n_err++; $display("FAIL near_sel_b: got %b want 01", sel_b); end
        // Load to r9 in EX plus a dependent in ID, then reset mid-cycle.
        drive(1, 1, 0, 1, 0, 9, 1, 1, 0);   tick();
        drive(1, 9, 9, 1, 1, 11, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (sel_a !== 2'b00) begin n_err++; $display("FAIL midrst_sel_a: got %b want 00", sel_a); end
        n_cmp++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL midrst_sel_b: got %b want 00", sel_b); end
        n_cmp++; if (bubble !== 1'b1) begin n_err++; $display("FAIL midrst_bubble: got %b want 1", bubble); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b want 0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
        // First post-reset instruction reads r9: no hazards remain.
        drive(1, 9, 9, 1, 1, 12, 1, 0, 0);
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL postrst_stall: got %b want 0", stall); end
        tick();
        n_cmp++; if (sel_a !== 2'b00) begin n_err++; $display("FAIL postrst_sel_a: got %b want 00", sel_a); end
        n_cmp++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL postrst_sel_b: got %b want 00", sel_b); end
        drain();
    endtask

    task automatic test_random();
        logic exp_stall;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0);
            exp_stall = m_stall();
            n_cmp++; if (stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, exp_stall); end
            tick();
            n_cmp++; if (sel_a !== exp_a) begin n_err++; $display("FAIL rnd_sel_a[%0d]: got %b want %b", i, sel_a, exp_a); end
            n_cmp++; if (sel_b !== exp_b) begin n_err++; $display("FAIL rnd_sel_b[%0d]: got %b want %b", i, sel_b, exp_b); end
            n_cmp++; if (bubble !== exp_bubble) begin n_err++; $display("FAIL rnd_bubble[%0d]: got %b want %b", i, bubble, exp_bubble); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_load_use();
        test_wb_distance();
        test_r0();
        test_flush();
        test_nearest_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard control for the EX-stage operand select muxes (4-to-1, n-bit, 2-bit select with bit 0 as MSB).
- Tracks the destination registers of in-flight instructions through EX, MEM and WB, and compares them against ID-stage sources.
- Produces the registered select codes consumed by the A and B operand muxes in EX, plus load-use stall and bubble control for IF/ID.

Parameters:
- RB, 5: register-index width.
- R0_HARDWIRED, 1: when 1, register index 0 never matches for forwarding or stall.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  RB  source 1 index.
- id_rs2  in  RB  source 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  RB  destination index.
- id_wr  in  1  instruction writes rd.
- id_load  in  1  instruction is a load.
- flush  in  1  taken branch/jump: kill the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID.
- bubble  out  1  registered; EX holds a bubble this cycle.
- sel_a  out  [0:1]  registered operand-A mux select for EX.
- sel_b  out  [0:1]  registered operand-B mux select for EX.

Behaviour:
- Three tracking slots: EX, MEM, WB. Each slot holds {v, rd, wr, ld}.
- A slot "matches" source r when: v=1, wr=1, rd==r, and not (R0_HARDWIRED and r==0).
- Select encoding, checked in priority order (nearest producer wins):
  - 01: EX slot matches. The EX/MEM ALU result is bypassed next cycle.
  - 10: MEM slot matches. MEM/WB result.
  - 11: WB slot matches. Late WB bypass; see Optional Feature.
  - 00: no match. Register-file value.
  - A source with its use bit = 0 always gets 00.
- Load-use stall: stall=1 when id_valid, flush=0, and the EX slot has ld=1 and matches a used source.
- Combinational stall path is limited to the ID-input and EX-slot compares; no path from sel outputs.
- Every clk edge:
  - WB<=MEM and MEM<=EX, unconditionally.
  - EX<=ID entry and sel_a/sel_b<=computed codes when id_valid=1, stall=0 and flush=0.
  - Otherwise EX<=bubble (v=0), sel_a=sel_b=00, bubble=1.
  - bubble=0 when a real instruction enters EX.
- Simultaneous flush and stall: flush wins. stall=0, EX gets a bubble.
- Back-to-back stalls cannot occur: after one stall cycle the load has moved to MEM, so the next compare yields 10.
- Reset (asynchronous, rst_n=0): all slot v=0, sel_a=sel_b=00, bubble=1. stall=0 since EX is empty.
- Deassert rst_n synchronously to clk externally. Mid-operation reset discards all tracking; the first post-reset instruction sees no hazards.
- Latency: selects are valid during the EX cycle of the instruction they were computed for (one register stage after ID).

Optional Feature:
- Macro: FWD_WB_BYPASS_EN.
- Defined: the WB slot participates in matching and code 11 is produced. Use with a register file that is not write-through.
- Undefined: WB slot is ignored for matching. Code 11 is never generated; a distance-3 dependence yields 00 (register file assumed write-through). WB slot storage may be removed.

Test Plan:
- add r3 in ID, sub r5,r3,r3 next -> in sub's EX cycle: sel_a=01, sel_b=01, stall=0 throughout.
- lw r4; add r6,r4,r1 -> one stall cycle, bubble=1 for 1 cycle, then add's EX cycle has sel_a=10, sel_b=00.
- Writer to r7 followed by two independent instructions, then a reader of r7:
  - with FWD_WB_BYPASS_EN: sel=11.
  - without: sel=00.
- Writer to r0, reader of r0 with R0_HARDWIRED=1 -> sel=00. Load to r0 followed by a use of r0 -> no stall.
- lw r2 in EX, dependent reader in ID, flush=1 the same cycle -> stall=0, next cycle bubble=1, sel=00.
- Sources match both EX (r9) and MEM (r9) slots -> sel=01 (nearest). Assert rst_n=0 mid-stream -> sel_a=sel_b=00 and bubble=1 immediately, stall=0.
